// File: rtl/p4_router_egr_queue.sv
// Store-and-forward egress packet queue: buffers whole packets with their egress tuser,
// drops on lack of space or oversize, and only releases a packet once it is fully committed.
module p4_router_egr_queue #(
   parameter int DATA_BYTES  = 64,
   parameter int USER_WIDTH  = 4,
   parameter int MTU_BYTES   = 9600,
   parameter int DEPTH_WORDS = 512,
   parameter int MAX_PKTS    = 32,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                          core_clk,
   input  logic                          core_areset,
   input  logic [8*DATA_BYTES-1:0]       s_tdata,
   input  logic [DATA_BYTES-1:0]         s_tkeep,
   input  logic                          s_tvalid,
   output logic                          s_tready,
   input  logic                          s_tlast,
   input  logic [USER_WIDTH-1:0]         s_tuser,
   output logic [8*DATA_BYTES-1:0]       m_tdata,
   output logic [DATA_BYTES-1:0]         m_tkeep,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic                          m_tlast,
   output logic [USER_WIDTH-1:0]         m_tuser,
   input  logic                          cnts_clear,
   output logic [CNT_WIDTH-1:0]          pkt_in_cnt,
   output logic [CNT_WIDTH-1:0]          pkt_out_cnt,
   output logic [CNT_WIDTH-1:0]          drop_full_cnt,
   output logic [CNT_WIDTH-1:0]          drop_mtu_cnt,
   output logic                          buf_full_drop,
   output logic [$clog2(DEPTH_WORDS):0]  fill_words
);
   localparam int MTU_WORDS = (MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES;
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(MAX_PKTS);
   localparam int LW = $clog2(MTU_WORDS + 1);
   localparam int DW = 8 * DATA_BYTES;
   localparam logic [LW-1:0] MTU_LEN = LW'(MTU_WORDS);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);
   localparam logic [AW:0] MTU_L = (AW+1)'(MTU_WORDS);

   if (DEPTH_WORDS < 2 * MTU_WORDS) begin : g_depth_check
      $error("DEPTH_WORDS must be at least twice the MTU in words");
   end

   typedef enum logic [1:0] {W_SOF, W_ACCEPT, W_DROP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rstate_t;

   wstate_t wstate;
   rstate_t rstate;

   logic [DW-1:0]         mem [DEPTH_WORDS];
   logic [LW-1:0]         desc_len [MAX_PKTS];
   logic [USER_WIDTH-1:0] desc_user [MAX_PKTS];
   logic [DATA_BYTES-1:0] desc_keep [MAX_PKTS];
   logic [DW-1:0]         skid_data [2];

   logic [AW:0]           wr_ptr, wr_ptr_spec, rd_ptr;
   logic [PW:0]           desc_wp, desc_rp, desc_count;
   logic [LW-1:0]         beat_cnt, commit_len, iss_left, out_left;
   logic [USER_WIDTH-1:0] wr_user, commit_user, cur_user;
   logic [DATA_BYTES-1:0] cur_keep;
   logic [1:0]            skid_cnt;
   logic                  skid_wr, skid_rd;
   logic accept, in_sof, in_acc, mtu_hit, admit_ok, mem_we, commit, full_ev, mtu_ev;
   logic desc_empty, desc_full, pop, last_out, pkt_done, desc_pop, issue;

   assign desc_count  = desc_wp - desc_rp;
   assign desc_empty  = (desc_count == '0);
   assign desc_full   = (desc_count == (PW+1)'(MAX_PKTS));
   assign fill_words  = wr_ptr_spec - rd_ptr;

   assign accept      = s_tvalid && s_tready;
   assign in_sof      = (wstate == W_SOF);
   assign in_acc      = (wstate == W_ACCEPT);
   assign mtu_hit     = in_acc && (beat_cnt == MTU_LEN);
   assign admit_ok    = ((DEPTH_L - fill_words) >= MTU_L) && !desc_full;
   assign mem_we      = accept && ((in_sof && admit_ok) || (in_acc && !mtu_hit));
   assign commit      = mem_we && s_tlast;
   assign full_ev     = accept && in_sof && !admit_ok;
   assign mtu_ev      = accept && mtu_hit;
   assign commit_len  = in_sof ? LW'(1) : beat_cnt + LW'(1);
   assign commit_user = in_sof ? s_tuser : wr_user;

   // Write side: speculative pointer runs ahead of the committed one until tlast.
   always_ff @(posedge core_clk or posedge core_areset) begin
      if (core_areset) begin
         wstate        <= W_SOF;
         wr_ptr        <= '0;
         wr_ptr_spec   <= '0;
         beat_cnt      <= '0;
         wr_user       <= '0;
         desc_wp       <= '0;
         s_tready      <= 1'b0;
         buf_full_drop <= 1'b0;
      end else begin
         s_tready      <= 1'b1;
         buf_full_drop <= full_ev;
         if (mem_we) begin
            wr_ptr_spec <= wr_ptr_spec + (AW+1)'(1);
            beat_cnt    <= commit_len;
         end
         if (mtu_ev) wr_ptr_spec <= wr_ptr;
         if (commit) begin
            wr_ptr  <= wr_ptr_spec + (AW+1)'(1);
            desc_wp <= desc_wp + (PW+1)'(1);
         end
         if (accept && in_sof && admit_ok) wr_user <= s_tuser;
         case (wstate)
            W_SOF: if (accept && !s_tlast) wstate <= admit_ok ? W_ACCEPT : W_DROP;
            W_ACCEPT: begin
               if (accept && mtu_hit) wstate <= s_tlast ? W_SOF : W_DROP;
               else if (accept && s_tlast) wstate <= W_SOF;
            end
            W_DROP: if (accept && s_tlast) wstate <= W_SOF;
            default: wstate <= W_SOF;
         endcase
      end
   end

   always_ff @(posedge core_clk) begin
      if (mem_we) mem[wr_ptr_spec[AW-1:0]] <= s_tdata;
      if (commit) begin
         desc_len[desc_wp[PW-1:0]]  <= commit_len;
         desc_user[desc_wp[PW-1:0]] <= commit_user;
         desc_keep[desc_wp[PW-1:0]] <= s_tkeep;
      end
      if (issue) skid_data[skid_wr] <= mem[rd_ptr[AW-1:0]];
   end

   assign m_tvalid = (skid_cnt != 2'd0);
   assign pop      = m_tvalid && m_tready;
   assign last_out = (out_left == LW'(1));
   assign m_tlast  = m_tvalid && last_out;
   assign pkt_done = pop && last_out;
   assign desc_pop = !desc_empty && ((rstate == R_IDLE) || (rstate == R_STREAM && pkt_done));
   assign issue    = (rstate != R_IDLE) && (iss_left != '0) && ((skid_cnt != 2'd2) || pop);
   assign m_tdata  = skid_data[skid_rd];
   assign m_tkeep  = last_out ? cur_keep : '1;
   assign m_tuser  = cur_user;

   // Read side: RAM reads land directly in the two-entry skid, keeping the stream bubble-free.
   always_ff @(posedge core_clk or posedge core_areset) begin
      if (core_areset) begin
         rstate   <= R_IDLE;
         rd_ptr   <= '0;
         desc_rp  <= '0;
         iss_left <= '0;
         out_left <= '0;
         cur_user <= '0;
         cur_keep <= '0;
         skid_cnt <= '0;
         skid_wr  <= 1'b0;
         skid_rd  <= 1'b0;
      end else begin
         if (desc_pop) begin
            desc_rp  <= desc_rp + (PW+1)'(1);
            iss_left <= desc_len[desc_rp[PW-1:0]];
            out_left <= desc_len[desc_rp[PW-1:0]];
            cur_user <= desc_user[desc_rp[PW-1:0]];
            cur_keep <= desc_keep[desc_rp[PW-1:0]];
         end else begin
            if (issue) iss_left <= iss_left - LW'(1);
            if (pop)   out_left <= out_left - LW'(1);
         end
         if (issue) begin
            rd_ptr  <= rd_ptr + (AW+1)'(1);
            skid_wr <= ~skid_wr;
         end
         if (pop) skid_rd <= ~skid_rd;
         skid_cnt <= skid_cnt + {1'b0, issue} - {1'b0, pop};
         case (rstate)
            R_IDLE:   if (!desc_empty) rstate <= R_LOAD;
            R_LOAD:   rstate <= R_STREAM;
            R_STREAM: if (pkt_done) rstate <= desc_empty ? R_IDLE : R_LOAD;
            default:  rstate <= R_IDLE;
         endcase
      end
   end

   function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v, input logic en);
      return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
   endfunction

   // Saturating statistics; a clear wins over an increment in the same cycle.
   always_ff @(posedge core_clk or posedge core_areset) begin
      if (core_areset) begin
         pkt_in_cnt    <= '0;
         pkt_out_cnt   <= '0;
         drop_full_cnt <= '0;
         drop_mtu_cnt  <= '0;
      end else if (cnts_clear) begin
         pkt_in_cnt    <= '0;
         pkt_out_cnt   <= '0;
         drop_full_cnt <= '0;
         drop_mtu_cnt  <= '0;
      end else begin
         pkt_in_cnt    <= bump(pkt_in_cnt, commit);
         pkt_out_cnt   <= bump(pkt_out_cnt, pkt_done);
         drop_full_cnt <= bump(drop_full_cnt, full_ev);
         drop_mtu_cnt  <= bump(drop_mtu_cnt, mtu_ev);
      end
   end
endmodule

// File: tb/tb_p4_router_egr_queue.sv
// Scoreboard bench for p4_router_egr_queue: stimulus pushes expected beats, a monitor pops and compares.
module tb_p4_router_egr_queue;
   localparam int DB = 64;
   localparam int UW = 4;
   localparam int DW = 8 * DB;
   localparam int DEPTH = 512;
   localparam int MTU_W = 150;
   localparam int MAXP = 32;

   logic core_clk, core_areset, cnts_clear;
   logic [DW-1:0] s_tdata, m_tdata, sat_tdata;
   logic [DB-1:0] s_tkeep, m_tkeep, sat_tkeep;
   logic s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast, buf_full_drop;
   logic [UW-1:0] s_tuser, m_tuser, sat_tuser;
   logic [31:0] pkt_in_cnt, pkt_out_cnt, drop_full_cnt, drop_mtu_cnt;
   logic [9:0] fill_words, sat_fill;
   logic sat_tready, sat_tvalid, sat_tlast, sat_full_drop;
   logic [1:0] sat_in, sat_out, sat_dfull, sat_dmtu;

   p4_router_egr_queue dut (
      .core_clk(core_clk), .core_areset(core_areset),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .m_tuser(m_tuser),
      .cnts_clear(cnts_clear), .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt),
      .drop_full_cnt(drop_full_cnt), .drop_mtu_cnt(drop_mtu_cnt),
      .buf_full_drop(buf_full_drop), .fill_words(fill_words));

   // Narrow-counter twin driven by the same stimulus, used to observe saturation.
   p4_router_egr_queue #(.CNT_WIDTH(2)) u_sat (
      .core_clk(core_clk), .core_areset(core_areset),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(sat_tready),
      .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tdata(sat_tdata), .m_tkeep(sat_tkeep), .m_tvalid(sat_tvalid), .m_tready(m_tready),
      .m_tlast(sat_tlast), .m_tuser(sat_tuser),
      .cnts_clear(cnts_clear), .pkt_in_cnt(sat_in), .pkt_out_cnt(sat_out),
      .drop_full_cnt(sat_dfull), .drop_mtu_cnt(sat_dmtu),
      .buf_full_drop(sat_full_drop), .fill_words(sat_fill));

   typedef struct {
      logic [DW-1:0] data;
      logic [DB-1:0] keep;
      logic          last;
      logic [UW-1:0] user;
   } beat_t;

   beat_t sb[$];
   beat_t mon_exp;
   int vectors = 0, miscompares = 0, pkt_pend = 0, cyc = 0, pulses = 0, ready_lows = 0;
   int last_beat_cyc = 0, lat;
   bit ready_watch = 0, rand_ready = 0, ready_level = 1;

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;
   always @(posedge core_clk) cyc <= cyc + 1;

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge core_clk);
         #1;
         m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_level;
      end
   end

   // Monitor: every output handshake must match the head of the expected queue.
   always @(negedge core_clk) begin
      if (buf_full_drop) pulses++;
      if (ready_watch && !s_tready) ready_lows++;
      if (!core_areset && m_tvalid && m_tready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_beat: got data=%h last=%b, required no beat", m_tdata[63:0], m_tlast);
         end else begin
            mon_exp = sb.pop_front();
            if (m_tdata !== mon_exp.data || m_tkeep !== mon_exp.keep ||
                m_tlast !== mon_exp.last || m_tuser !== mon_exp.user) begin
               miscompares++;
               $display("[TB] FAIL out_beat: got keep=%h last=%b user=%h data=%h, required keep=%h last=%b user=%h data=%h",
                        m_tkeep, m_tlast, m_tuser, m_tdata, mon_exp.keep, mon_exp.last, mon_exp.user, mon_exp.data);
            end
            if (mon_exp.last) pkt_pend--;
         end
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic [DB-1:0] keep_mask(input int n);
      logic [DB-1:0] m;
      m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic apply_stimulus(input int len, input int last_bytes, input logic [UW-1:0] user,
                                 input bit expect_ok, input bit clear_on_last);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
         b.last = (i == len - 1);
         b.keep = b.last ? keep_mask(last_bytes) : '1;
         b.user = user;
         if (expect_ok) begin
            sb.push_back(b);
            if (b.last) pkt_pend++;
         end
         s_tdata = b.data; s_tkeep = b.keep; s_tlast = b.last; s_tuser = user; s_tvalid = 1'b1;
         cnts_clear = clear_on_last && b.last;
         last_beat_cyc = cyc;
         @(posedge core_clk);
         #1;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; cnts_clear = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 20000) begin
         @(posedge core_clk);
         n++;
      end
      check_output("drain", sb.size(), 0);
      repeat (4) @(posedge core_clk);
      #1;
   endtask

   task automatic clear_counters();
      cnts_clear = 1'b1;
      @(posedge core_clk);
      #1;
      cnts_clear = 1'b0;
   endtask

   initial begin
      core_areset = 1'b1; cnts_clear = 1'b0;
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
      repeat (3) @(posedge core_clk);
      #1;
      check_output("rst_m_tvalid", m_tvalid, 0);
      check_output("rst_s_tready", s_tready, 0);
      check_output("rst_fill", fill_words, 0);
      check_output("rst_pkt_in", pkt_in_cnt, 0);
      check_output("rst_drop_full", drop_full_cnt, 0);
      check_output("rst_full_pulse", buf_full_drop, 0);
      core_areset = 1'b0;
      @(posedge core_clk);
      #1;
      check_output("ready_after_rst", s_tready, 1);

      // 100-byte packet: two beats, 36 valid bytes on the last.
      apply_stimulus(2, 36, 4'd3, 1, 0);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge core_clk);
         if (m_tvalid) begin
            lat = cyc - last_beat_cyc;
            break;
         end
      end
      check_output("latency", lat, 3);
      wait_drain();
      check_output("t1_pkt_in", pkt_in_cnt, 1);
      check_output("t1_pkt_out", pkt_out_cnt, 1);

      // Output stalled: fourth 150-word packet finds too little room.
      clear_counters();
      pulses = 0; ready_lows = 0; ready_watch = 1; ready_level = 0;
      repeat (2) @(posedge core_clk);
      #1;
      for (int p = 0; p < 3; p++) apply_stimulus(MTU_W, DB, 4'($urandom_range(0, 15)), 1, 0);
      apply_stimulus(MTU_W, DB, 4'd6, 0, 0);
      @(posedge core_clk);
      #1;
      ready_watch = 0;
      check_output("full_drop_cnt", drop_full_cnt, 1);
      check_output("full_pulses", pulses, 1);
      check_output("full_pkt_in", pkt_in_cnt, 3);
      check_output("s_tready_lows", ready_lows, 0);
      ready_level = 1;
      wait_drain();
      check_output("full_pkt_out", pkt_out_cnt, 3);
      check_output("full_fill_empty", fill_words, 0);

      // Oversize packet rolls back, the next small one gets through.
      clear_counters();
      apply_stimulus(160, DB, 4'd5, 0, 0);
      check_output("mtu_drop_cnt", drop_mtu_cnt, 1);
      check_output("mtu_fill_restored", fill_words, 0);
      apply_stimulus(1, 10, 4'd9, 1, 0);
      wait_drain();
      check_output("mtu_pkt_in", pkt_in_cnt, 1);
      check_output("mtu_pkt_out", pkt_out_cnt, 1);

      // Random traffic; admission is guaranteed by limiting what is outstanding.
      clear_counters();
      rand_ready = 1;
      for (int p = 0; p < 200; p++) begin
         int g = 0;
         while ((sb.size() > DEPTH - MTU_W || pkt_pend >= MAXP) && g < 20000) begin
            @(posedge core_clk);
            #1;
            g++;
         end
         if (g >= 20000) check_output("gate_wait_expired", g, 0);
         apply_stimulus($urandom_range(1, MTU_W), $urandom_range(1, DB), 4'($urandom_range(0, 15)), 1, 0);
      end
      wait_drain();
      rand_ready = 0;
      check_output("rand_pkt_in", pkt_in_cnt, 200);
      check_output("rand_pkt_out", pkt_out_cnt, 200);
      check_output("rand_drop_full", drop_full_cnt, 0);
      check_output("rand_drop_mtu", drop_mtu_cnt, 0);

      // Clear on the commit cycle, then saturation of the narrow twin.
      apply_stimulus(2, 8, 4'd1, 1, 1);
      check_output("clear_vs_commit", pkt_in_cnt, 0);
      wait_drain();
      for (int p = 0; p < 4; p++) apply_stimulus(1, 4, 4'd2, 1, 0);
      wait_drain();
      check_output("post_clear_pkt_in", pkt_in_cnt, 4);
      check_output("post_clear_pkt_out", pkt_out_cnt, 5);
      check_output("sat_pkt_in", sat_in, 2'b11);
      check_output("sat_pkt_out", sat_out, 2'b11);

      // Reset while one packet streams out and another streams in.
      apply_stimulus(100, DB, 4'd2, 1, 0);
      for (int i = 0; i < 19; i++) begin
         for (int w = 0; w < DW / 32; w++) s_tdata[w*32 +: 32] = $urandom();
         s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
         @(posedge core_clk);
         #1;
      end
      check_output("stream_before_rst", m_tvalid, 1);
      core_areset = 1'b1;
      sb.delete();
      pkt_pend = 0;
      #1;
      check_output("rst_mid_m_tvalid", m_tvalid, 0);
      check_output("rst_mid_pkt_in", pkt_in_cnt, 0);
      check_output("rst_mid_pkt_out", pkt_out_cnt, 0);
      check_output("rst_mid_fill", fill_words, 0);
      s_tvalid = 1'b0;
      repeat (2) @(posedge core_clk);
      #1;
      core_areset = 1'b0;
      @(posedge core_clk);
      #1;
      apply_stimulus(5, 20, 4'd7, 1, 0);
      wait_drain();
      check_output("after_rst_pkt_in", pkt_in_cnt, 1);
      check_output("after_rst_pkt_out", pkt_out_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
